// File: rtl/ifetch_resp_pkg.sv
// Shared definitions for the instruction-fetch response block.
//   DMW_SEG_W / DMW_MAT_W : direct-map window field widths
//   RESET_PC              : fetch reset pc
//   mat_e                 : memory access type encodings for the DMW
//   ptr_w()               : pointer width for a FIFO of a given depth
package ifetch_resp_pkg;

  localparam int unsigned DMW_SEG_W = 3;
  localparam int unsigned DMW_MAT_W = 2;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  typedef enum logic [DMW_MAT_W-1:0] {
    MAT_SUC = 2'd0,  // strongly-ordered uncached
    MAT_CC  = 2'd1   // coherent cached
  } mat_e;

  // A single-entry FIFO still needs a one-bit pointer to index its storage.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ifetch_resp_if.sv
// Fetch-stage and memory-side handshake bundle for ifetch_resp.
//   valid/iaddr/uncached -> addr_ok       : fetch request / accept
//   flush                                 : cancel outstanding fetches
//   data_ok/rdata                         : instruction return to fetch stage
//   rd_req/rd_addr/rd_uncached <- rd_rdy  : memory read request
//   ret_valid/ret_data                    : in-order memory return
// slave is the ifetch_resp side; master is the fetch stage + memory side.
interface ifetch_resp_if;

  logic        valid;
  logic [31:0] iaddr;
  logic        uncached;
  logic        addr_ok;
  logic        flush;
  logic        data_ok;
  logic [31:0] rdata;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_uncached;
  logic        rd_rdy;
  logic        ret_valid;
  logic [31:0] ret_data;

  modport slave (
    input  valid, iaddr, uncached, flush, rd_rdy, ret_valid, ret_data,
    output addr_ok, data_ok, rdata, rd_req, rd_addr, rd_uncached
  );

  modport master (
    output valid, iaddr, uncached, flush, rd_rdy, ret_valid, ret_data,
    input  addr_ok, data_ok, rdata, rd_req, rd_addr, rd_uncached
  );

endinterface

// File: rtl/ifetch_resp_trk_fifo.sv
// In-order tracking FIFO of outstanding fetches; each entry holds a kill bit.
//   clk, rst  : clock, synchronous active-high reset
//   push      : enqueue one entry (ignored when full)
//   pop       : dequeue oldest entry (ignored when empty)
//   kill_all  : mark every occupied entry killed, including one pushed now
//   head_kill : kill state of the oldest entry as seen by a pop this cycle
//   full      : count == DEPTH
//   empty     : count == 0
module ifetch_trk_fifo
  import ifetch_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic kill_all,
  output logic head_kill,
  output logic full,
  output logic empty
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic [(1<<PW)-1:0]   kill;
  logic                 push_eff;
  logic                 pop_eff;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_eff = push && !full;
  assign pop_eff  = pop && !empty;

  // A flush in the same cycle as a pop kills the departing entry too.
  assign head_kill = kill[rd_ptr] | kill_all;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      kill   <= '0;
    end else begin
      if (push_eff) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_eff)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Unoccupied slots may be marked too; a later push overwrites its slot.
      if (kill_all) kill <= '1;
      if (push_eff) kill[wr_ptr] <= kill_all;
    end
  end

endmodule

// File: rtl/ifetch_resp.sv
// Instruction-fetch response tracker with direct-map-window translation.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : fetch request/return and memory read handshake
//   viaddrh         : virtual pc bits [31:29]
//   piaddrh         : translated physical bits [31:29]
//   iuncached       : translated region is uncached
//   dmw_*           : direct-map window configuration
// Accepted fetches are tracked in order; returns for flushed fetches are
// dropped, surviving returns are presented one cycle later on data_ok/rdata.
module ifetch_resp
  import ifetch_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ifetch_resp_if.slave         bus,
  input  logic [DMW_SEG_W-1:0] viaddrh,
  output logic [DMW_SEG_W-1:0] piaddrh,
  output logic                 iuncached,
  input  logic                 dmw_en,
  input  logic [DMW_SEG_W-1:0] dmw_vseg,
  input  logic [DMW_SEG_W-1:0] dmw_pseg,
  input  logic [DMW_MAT_W-1:0] dmw_mat
);

  logic full;
  logic empty;
  logic head_kill;
  logic accept;

  always_comb begin
    piaddrh   = viaddrh;
    iuncached = 1'b0;
    if (dmw_en && (viaddrh == dmw_vseg)) begin
      piaddrh   = dmw_pseg;
      iuncached = (dmw_mat == MAT_SUC);
    end
  end

  assign bus.rd_req      = bus.valid && !full && !rst;
  assign bus.rd_addr     = bus.iaddr;
  assign bus.rd_uncached = bus.uncached;
  assign accept          = bus.rd_req && bus.rd_rdy;
  assign bus.addr_ok     = accept;

  ifetch_trk_fifo #(.DEPTH(DEPTH)) u_trk (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .pop       (bus.ret_valid),
    .kill_all  (bus.flush),
    .head_kill (head_kill),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_ok <= 1'b0;
      bus.rdata   <= '0;
    end else begin
      bus.data_ok <= bus.ret_valid && !empty && !head_kill;
      if (bus.ret_valid && !empty && !head_kill) bus.rdata <= bus.ret_data;
    end
  end

endmodule

// File: tb/tb_ifetch_resp.sv
module tb_ifetch_resp;
  import ifetch_resp_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] viaddrh, piaddrh, dmw_vseg, dmw_pseg;
  logic [1:0] dmw_mat;
  logic       iuncached, dmw_en;

  ifetch_resp_if bus ();

  ifetch_resp #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .viaddrh   (viaddrh),
    .piaddrh   (piaddrh),
    .iuncached (iuncached),
    .dmw_en    (dmw_en),
    .dmw_vseg  (dmw_vseg),
    .dmw_pseg  (dmw_pseg),
    .dmw_mat   (dmw_mat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: outstanding fetches as a queue of kill flags, and the
  // data words the fetch stage must see, in order, one cycle after return.
  bit          out_q[$];
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance the model.
  task automatic cycle(input bit v, input logic [31:0] a, input bit u, input bit rdy,
                       input bit rv, input logic [31:0] rd, input bit fl, input bit r);
    bit acc;
    bit k;
    logic [2:0] e_ph;
    bit e_unc;
    #1;
    bus.valid = v; bus.iaddr = a; bus.uncached = u; bus.rd_rdy = rdy;
    bus.ret_valid = rv; bus.ret_data = rd; bus.flush = fl; rst = r;
    #1;
    acc = v && !r && rdy && (out_q.size() < DEPTH);
    chk("rd_req", 32'(bus.rd_req), 32'(v && !r && (out_q.size() < DEPTH)));
    chk("addr_ok", 32'(bus.addr_ok), 32'(acc));
    if (bus.rd_req) begin
      chk("rd_addr", bus.rd_addr, a);
      chk("rd_uncached", 32'(bus.rd_uncached), 32'(u));
    end
    if (dmw_en && viaddrh == dmw_vseg) begin
      e_ph = dmw_pseg; e_unc = (dmw_mat == 2'd0);
    end else begin
      e_ph = viaddrh; e_unc = 1'b0;
    end
    chk("piaddrh", 32'(piaddrh), 32'(e_ph));
    chk("iuncached", 32'(iuncached), 32'(e_unc));
    @(posedge clk);
    if (r) begin
      out_q.delete();
    end else begin
      if (rv && out_q.size() > 0) begin
        k = out_q.pop_front();
        if (!(k || fl)) exp_q.push_back(rd);
      end
      if (fl) foreach (out_q[i]) out_q[i] = 1'b1;
      if (acc) out_q.push_back(fl);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 0, '0, 0, 0);
  endtask

  // Monitor: every cycle data_ok must match the scoreboard, and rdata the head.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      chk("data_ok", 32'(bus.data_ok), 32'(exp_q.size() != 0));
      if (bus.data_ok && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rdata", bus.rdata, e);
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    dmw_en = 0; dmw_vseg = '0; dmw_pseg = '0; dmw_mat = '0; viaddrh = '0;
    cycle(0, '0, 0, 0, 0, '0, 0, 1);
    cycle(0, '0, 0, 0, 0, '0, 0, 1);
    #1;
    chk("rdata_reset", bus.rdata, 32'h0);
    chk("data_ok_reset", 32'(bus.data_ok), 32'h0);

    // Single fetch
    cycle(1, RESET_PC, 0, 1, 0, '0, 0, 0);
    cycle(0, '0, 0, 0, 1, 32'h0280_0000, 0, 0);
    idle(2);

    // Back-pressure: fill, stall, free one slot
    cycle(1, 32'h1c00_0004, 0, 1, 0, '0, 0, 0);
    cycle(1, 32'h1c00_0008, 0, 1, 0, '0, 0, 0);
    cycle(1, 32'h1c00_000c, 0, 1, 0, '0, 0, 0);
    cycle(1, 32'h1c00_000c, 0, 1, 1, 32'h1111_1111, 0, 0);
    cycle(1, 32'h1c00_000c, 0, 1, 0, '0, 0, 0);
    cycle(0, '0, 0, 0, 1, 32'h2222_2222, 0, 0);
    cycle(0, '0, 0, 0, 1, 32'h3333_3333, 0, 0);
    idle(1);

    // Flush with two outstanding, then a normal fetch
    cycle(1, 32'h1c00_0010, 0, 1, 0, '0, 0, 0);
    cycle(1, 32'h1c00_0014, 0, 1, 0, '0, 0, 0);
    cycle(0, '0, 0, 0, 0, '0, 1, 0);
    cycle(0, '0, 0, 0, 1, 32'hdead_0001, 0, 0);
    cycle(0, '0, 0, 0, 1, 32'hdead_0002, 0, 0);
    cycle(1, 32'h1c00_0018, 0, 1, 0, '0, 0, 0);
    cycle(0, '0, 0, 0, 1, 32'h4444_4444, 0, 0);

    // Flush in the push cycle, and flush coincident with a return
    cycle(1, 32'h1c00_001c, 0, 1, 0, '0, 1, 0);
    cycle(0, '0, 0, 0, 1, 32'hdead_0003, 0, 0);
    cycle(1, 32'h1c00_0020, 0, 1, 0, '0, 0, 0);
    cycle(0, '0, 0, 0, 1, 32'hdead_0004, 1, 0);

    // Translation
    dmw_en = 1; dmw_vseg = 3'b101; dmw_pseg = 3'b000; dmw_mat = 2'd0;
    viaddrh = 3'b101; idle(1);
    viaddrh = 3'b001; idle(1);

    // Reset mid-flight and a spurious return
    cycle(1, 32'h1c00_0024, 0, 1, 0, '0, 0, 0);
    cycle(0, '0, 0, 0, 0, '0, 0, 1);
    cycle(0, '0, 0, 0, 1, 32'hdead_0005, 0, 0);
    idle(1);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      bit rv;
      dmw_en = 1'($urandom_range(0, 1));
      dmw_vseg = 3'($urandom); dmw_pseg = 3'($urandom); dmw_mat = 2'($urandom);
      viaddrh = ($urandom_range(0, 1) != 0) ? dmw_vseg : 3'($urandom);
      rv = (out_q.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 5);
      cycle($urandom_range(0, 99) < 70, $urandom, 1'($urandom), $urandom_range(0, 99) < 70,
            rv, $urandom, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 1);
    end
    // Drain remaining returns
    for (int n = 0; n < 2 * DEPTH && out_q.size() > 0; n++)
      cycle(0, '0, 0, 0, 1, $urandom, 0, 0);
    idle(2);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_resp.md
IFETCH_RESP -- requirements
Module: ifetch_resp

Interface
REQ-001 Parameter DEPTH, default 2: maximum outstanding fetches, legal values 1..4.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 valid  in  1  fetch request from the fetch stage.
REQ-005 iaddr  in  32  physical fetch address, word aligned.
REQ-006 uncached  in  1  request-side uncached hint.
REQ-007 addr_ok  out  1  request accepted this cycle.
REQ-008 viaddrh  in  3  virtual address bits [31:29] of the current fetch pc.
REQ-009 piaddrh  out  3  translated physical bits [31:29].
REQ-010 iuncached  out  1  translated region is uncached.
REQ-011 flush  in  1  cancel all outstanding fetches.
REQ-012 data_ok  out  1  rdata valid, one pulse per surviving fetch.
REQ-013 rdata  out  32  instruction word.
REQ-014 dmw_en, dmw_vseg[2:0], dmw_pseg[2:0], dmw_mat[1:0]  in  direct-map window configuration.
REQ-015 rd_req  out  1; rd_addr  out  32; rd_uncached  out  1: memory read request.
REQ-016 rd_rdy  in  1  memory accepts rd_req this cycle.
REQ-017 ret_valid  in  1; ret_data  in  32: in-order memory return.

Function
REQ-018 Translation is combinational: dmw_en && viaddrh==dmw_vseg -> piaddrh=dmw_pseg, iuncached=(dmw_mat==0); else piaddrh=viaddrh, iuncached=0.
REQ-019 rd_req = valid && !full && !rst; rd_addr = iaddr; rd_uncached = uncached.
REQ-020 addr_ok = rd_req && rd_rdy; a fetch is accepted exactly when addr_ok=1.
REQ-021 Each accepted fetch pushes one tracking entry {kill} into an in-order FIFO of DEPTH entries; full when count==DEPTH.
REQ-022 Each ret_valid pops the oldest entry; if the popped kill=0, data_ok=1 and rdata=ret_data on the next cycle (registered, 1-cycle latency).
REQ-023 Popped entry with kill=1: data is discarded and data_ok stays 0.
REQ-024 Push and pop in the same cycle: count unchanged; a full FIFO accepts no push even if a pop occurs that cycle (addr_ok uses the registered count).
REQ-025 flush=1 sets kill on every occupied entry, including an entry pushed in the same cycle.
REQ-026 flush coincident with ret_valid: the popped entry is killed (no data_ok).
REQ-027 ret_valid with count==0 is ignored; count saturates at 0, no data_ok.
REQ-028 Pointers wrap modulo DEPTH; count width is clog2(DEPTH+1).
REQ-029 data_ok is 0 in every cycle without a qualifying return; rdata holds its last value otherwise.

Reset
REQ-030 On rst: count=0, pointers=0, all kill bits=0, data_ok=0, rdata=0.
REQ-031 rst asserted mid-operation abandons all outstanding entries; addr_ok and rd_req are 0 while rst=1.
REQ-032 The memory side is reset together with this block, so pre-reset returns never arrive.

Structure
REQ-033 The DMW field widths and the fetch reset pc 32'h1c000000 belong in the shared define header.
REQ-034 The tracking FIFO is one sub-module, ifetch_trk_fifo (push, pop, kill_all, head_kill, full, empty).
REQ-035 Translation and handshake glue live in ifetch_resp; there is no other hierarchy.

Verification
REQ-036 Single fetch: valid=1, iaddr=32'h1c000000, rd_rdy=1; cycle N ret_valid=1, ret_data=32'h02800000 -> addr_ok same cycle, data_ok=1 and rdata=32'h02800000 at N+1.
REQ-037 Back-pressure: DEPTH=2, two fetches accepted, no returns -> third cycle addr_ok=0, rd_req=0; one return -> addr_ok=1 the following cycle.
REQ-038 Flush: two outstanding, flush=1, then two returns -> no data_ok; a new fetch after that returns normally with data_ok=1.
REQ-039 Flush in push cycle: accept in the flush cycle, return later -> no data_ok.
REQ-040 Translation: dmw_en=1, vseg=3'b101, pseg=3'b000, mat=0, viaddrh=3'b101 -> piaddrh=3'b000, iuncached=1; viaddrh=3'b001 -> piaddrh=3'b001, iuncached=0.
REQ-041 Reset mid-flight: one outstanding, rst pulse -> count=0, data_ok=0; a spurious ret_valid is ignored.
